// File: rtl/bcd_digit_counter.sv
// bcd_digit_counter: prescaled multi-digit BCD up/down counter with wrap pulse on cy.
// Define BCD_CNT_SAT_EN to saturate at all-0s/all-9s instead of wrapping.
module bcd_digit_counter #(
  parameter int DIGITS   = 2,
  parameter int PRESCALE = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  up_dn,
  input  logic                  clear,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  cy
);
  localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);
  logic [PW-1:0]       r_pre;
  logic [4*DIGITS-1:0] r_bcd, w_next, w_load;
  logic                r_cy, w_step, w_wrap;
  assign w_step = en && r_pre == PMAX;
  // w_wrap doubles as the ripple carry/borrow; it ends true only when every digit sat at its limit
  always_comb begin
    w_next = r_bcd;
    w_load = '0;
    w_wrap = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      w_load[4*k +: 4] = load_val[4*k +: 4] > 4'd9 ? 4'd9 : load_val[4*k +: 4];
      if (w_wrap)
        w_next[4*k +: 4] = up_dn ? (r_bcd[4*k +: 4] == 4'd9 ? 4'd0 : r_bcd[4*k +: 4] + 4'd1)
                                 : (r_bcd[4*k +: 4] == 4'd0 ? 4'd9 : r_bcd[4*k +: 4] - 4'd1);
      w_wrap = w_wrap && r_bcd[4*k +: 4] == (up_dn ? 4'd9 : 4'd0);
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bcd <= '0;
      r_pre <= '0;
      r_cy  <= 1'b0;
    end else if (clear) begin
      r_bcd <= '0;
      r_pre <= '0;
      r_cy  <= 1'b0;
    end else if (load) begin
      r_bcd <= w_load;
      r_pre <= '0;
      r_cy  <= 1'b0;
    end else begin
      r_cy <= w_step && w_wrap;
      if (en) r_pre <= w_step ? '0 : r_pre + 1'b1;
`ifdef BCD_CNT_SAT_EN
      if (w_step && !w_wrap) r_bcd <= w_next;
`else
      if (w_step) r_bcd <= w_next;
`endif
    end
  end
  assign bcd = r_bcd;
  assign cy  = r_cy;
endmodule
